ikaopm_dac_rx: RTL and testbench
================================

IKAOPM_DAC_RX -- requirements
Module: ikaopm_dac_rx

Interface
REQ-001 Parameter CHANNELS, default 2: number of SH load strobes/output channels, legal 1..8; channel 0 = right (SH1), channel 1 = left (SH2).
REQ-002 Parameter OUT_WIDTH, default 16: output sample width, legal 16..24; the 16-bit result is left-aligned, low bits zero.
REQ-003 Parameter FRAME_BITS, default 13: minimum serial bits between loads before a frame is valid.
REQ-004 i_EMUCLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_IC_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_phi1_PCEN_n  in  1  active-low enable marking the phi1 rising edge.
REQ-007 i_phi1_NCEN_n  in  1  active-low enable marking the phi1 falling edge.
REQ-008 i_SO  in  1  serial sample data, LSB first.
REQ-009 i_SH  in  CHANNELS  per-channel sample-hold strobes.
REQ-010 i_ERR_CLR  in  1  synchronous clear of sticky error flags.
REQ-011 o_SAMPLE  out  CHANNELS*OUT_WIDTH  signed samples, channel n at bits [n*OUT_WIDTH +: OUT_WIDTH].
REQ-012 o_VALID  out  CHANNELS  one-EMUCLK pulse per new o_SAMPLE word.
REQ-013 o_FRAME_ERR  out  CHANNELS  sticky short-frame flag.
REQ-014 o_EXP0_ERR  out  CHANNELS  sticky exponent-zero flag.

Function
REQ-015 Shared 13-bit shift register shall shift on each PCEN cycle: sr <= {i_SO, sr[12:1]}.
REQ-016 Per channel, sh_z shall sample i_SH[n] on PCEN; sh_zz shall sample sh_z on NCEN.
REQ-017 load_cond[n] = ~sh_z & sh_zz; load event = load_cond rising edge detected in EMUCLK domain (one event per strobe).
REQ-018 On load event, latch[n] shall capture sr[12:0] in that cycle; decode registered next cycle, o_VALID[n] high that cycle only (latency 1 EMUCLK from load event).
REQ-019 Decode: e = latch[12:10], m = latch[9:0]; for e in 1..7, m[9]=1: +(m[8:0] << (e-1)); m[9]=0: -((~m[8:0]) << (e-1)); 16-bit two's complement.
REQ-020 e = 0: sample shall be 0, o_EXP0_ERR[n] set, o_VALID[n] still pulsed.
REQ-021 Per-channel bit counter shall increment on PCEN, saturate at 15, clear on that channel's load event.
REQ-022 Load event with counter < FRAME_BITS shall set o_FRAME_ERR[n]; sample still updated.
REQ-023 Simultaneous load on several channels shall latch identical sr contents into each; all assert o_VALID together.
REQ-024 i_ERR_CLR coincident with a new error shall leave the flag set (set wins).
REQ-025 o_SAMPLE shall hold between loads; no channel affects another's sample, counter or flags.
REQ-026 PCEN and NCEN both asserted in one cycle: PCEN actions first, NCEN samples pre-update sh_z.

Reset
REQ-027 i_IC_n low shall asynchronously clear sr, sh_z, sh_zz, edge state, latches, o_SAMPLE, o_VALID, o_FRAME_ERR, o_EXP0_ERR to 0; counters to 15.
REQ-028 Reset mid-frame shall discard the partial frame; no o_VALID until a full load event after release.

Structure
REQ-029 Shared package ikaopm_pkg shall hold FRAME_BITS default, exponent/mantissa field positions, counter saturation value.
REQ-030 Sub-module ikaopm_dac_float_dec (combinational 13-bit to 16-bit decoder) shall be instantiated once per channel.

Verification
REQ-031 Shift 13-bit word 0x0FFF (e=3, m=0x3FF), pulse SH1 -> o_SAMPLE[ch0]=0x07FC, o_VALID[0] one cycle, no flags.
REQ-032 Word e=7, m=0x000 on SH2 -> o_SAMPLE[ch1]=0x8040 (-32704); ch0 unchanged.
REQ-033 Word e=0 -> sample 0x0000, o_EXP0_ERR set; i_ERR_CLR pulse -> flag cleared.
REQ-034 SH1 pulse after only 8 PCEN bits -> o_FRAME_ERR[0]=1, sample updated; next 13-bit frame no new error.
REQ-035 OUT_WIDTH=24, word e=1 m=0x201 -> o_SAMPLE=0x000100; assert i_IC_n mid-frame -> all outputs 0, no spurious o_VALID.

Source files
------------

// File: rtl/ikaopm_pkg.sv
// Shared constants and the serial float word layout for the OPM DAC receiver.
package ikaopm_pkg;

  localparam int unsigned FRAME_BITS_DEF = 13;
  localparam int unsigned EXP_W          = 3;
  localparam int unsigned MAN_W          = 10;
  localparam int unsigned SR_W           = EXP_W + MAN_W;
  localparam int unsigned SIGN_BIT       = MAN_W - 1;
  localparam int unsigned DEC_W          = 16;
  localparam int unsigned CNT_W          = 4;
  localparam logic [CNT_W-1:0] CNT_SAT   = 4'd15;

  // Serial word as latched: exponent in the top bits, sign-flagged mantissa below.
  typedef struct packed {
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp_word_t;

endpackage

// File: rtl/ikaopm_dac_float_dec.sv
// Combinational decode of one 13-bit floating DAC word into a 16-bit two's complement sample.
module ikaopm_dac_float_dec
  import ikaopm_pkg::*;
(
  input  logic [SR_W-1:0]  word_i,
  output logic [DEC_W-1:0] sample_c_o,
  output logic             exp0_c_o
);

  fp_word_t              w;
  logic [3:0]            shamt;
  logic [SIGN_BIT-1:0]   frac_inv;
  logic [DEC_W-1:0]      mag;

  // Sign bit set: positive mantissa; clear: negated inverted mantissa.
  always_comb begin
    w          = fp_word_t'(word_i);
    shamt      = 4'(w.e) - 4'd1;
    frac_inv   = ~w.m[SIGN_BIT-1:0];
    exp0_c_o   = (w.e == '0);
    mag        = w.m[SIGN_BIT] ? DEC_W'(w.m[SIGN_BIT-1:0]) : DEC_W'(frac_inv);
    sample_c_o = '0;
    if (!exp0_c_o) begin
      sample_c_o = w.m[SIGN_BIT] ? (mag << shamt) : (DEC_W'(0) - (mag << shamt));
    end
  end

endmodule

// File: rtl/ikaopm_dac_rx.sv
// Receives the OPM serial DAC stream, latches a word per SH strobe and decodes it
// into a left-aligned signed sample per channel, with sticky frame/exponent errors.
module ikaopm_dac_rx
  import ikaopm_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                          i_EMUCLK,
  input  logic                          i_IC_n,
  input  logic                          i_phi1_PCEN_n,
  input  logic                          i_phi1_NCEN_n,
  input  logic                          i_SO,
  input  logic [CHANNELS-1:0]           i_SH,
  input  logic                          i_ERR_CLR,
  output logic [CHANNELS*OUT_WIDTH-1:0] o_SAMPLE,
  output logic [CHANNELS-1:0]           o_VALID,
  output logic [CHANNELS-1:0]           o_FRAME_ERR,
  output logic [CHANNELS-1:0]           o_EXP0_ERR
);

  localparam int unsigned PAD_W = OUT_WIDTH - DEC_W;

  logic            pcen;
  logic            ncen;
  logic [SR_W-1:0] sr_q;
  logic [SR_W-1:0] sr_d;

  assign pcen = ~i_phi1_PCEN_n;
  assign ncen = ~i_phi1_NCEN_n;

  // Shared shift register, LSB arrives first.
  always_comb begin
    sr_d = sr_q;
    if (pcen) sr_d = {i_SO, sr_q[SR_W-1:1]};
  end

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic                 sh_z_q, sh_z_d;
    logic                 sh_zz_q, sh_zz_d;
    logic                 ldc_q, ldc_d;
    logic                 load_evt;
    logic [SR_W-1:0]      latch_q, latch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 short_q, short_d;
    logic [OUT_WIDTH-1:0] smp_q, smp_d;
    logic                 vld_q, vld_d;
    logic                 ferr_q, ferr_d;
    logic                 eerr_q, eerr_d;
    logic [DEC_W-1:0]     dec;
    logic                 dec_exp0;

    ikaopm_dac_float_dec u_dec (
      .word_i     (latch_q),
      .sample_c_o (dec),
      .exp0_c_o   (dec_exp0)
    );

    // Strobe capture, load detect, frame counting and sticky error update.
    always_comb begin
      sh_z_d   = pcen ? i_SH[ch] : sh_z_q;
      sh_zz_d  = ncen ? sh_z_q : sh_zz_q;
      ldc_d    = ~sh_z_q & sh_zz_q;
      load_evt = ldc_d & ~ldc_q;
      latch_d  = load_evt ? sr_q : latch_q;
      pend_d   = load_evt;
      short_d  = load_evt ? (32'(cnt_q) < FRAME_BITS) : short_q;
      cnt_d    = cnt_q;
      if (load_evt)                    cnt_d = '0;
      else if (pcen && cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
      vld_d    = pend_q;
      smp_d    = pend_q ? (OUT_WIDTH'(dec) << PAD_W) : smp_q;
      ferr_d   = (ferr_q & ~i_ERR_CLR) | (pend_q & short_q);
      eerr_d   = (eerr_q & ~i_ERR_CLR) | (pend_q & dec_exp0);
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
        sh_z_q  <= 1'b0;
        sh_zz_q <= 1'b0;
        ldc_q   <= 1'b0;
        latch_q <= '0;
        cnt_q   <= CNT_SAT;
        pend_q  <= 1'b0;
        short_q <= 1'b0;
        smp_q   <= '0;
        vld_q   <= 1'b0;
        ferr_q  <= 1'b0;
        eerr_q  <= 1'b0;
      end else begin
        sh_z_q  <= sh_z_d;
        sh_zz_q <= sh_zz_d;
        ldc_q   <= ldc_d;
        latch_q <= latch_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        short_q <= short_d;
        smp_q   <= smp_d;
        vld_q   <= vld_d;
        ferr_q  <= ferr_d;
        eerr_q  <= eerr_d;
      end
    end

    assign o_SAMPLE[ch*OUT_WIDTH +: OUT_WIDTH] = smp_q;
    assign o_VALID[ch]     = vld_q;
    assign o_FRAME_ERR[ch] = ferr_q;
    assign o_EXP0_ERR[ch]  = eerr_q;
  end

endmodule

// File: tb/tb_ikaopm_dac_rx.sv
// Self-checking bench for ikaopm_dac_rx: phi1-level stimulus, integer-arithmetic reference model.
module tb_ikaopm_dac_rx;

  localparam int unsigned CH = 2;
  localparam int unsigned OW = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              pcen_n = 1'b1;
  logic              ncen_n = 1'b1;
  logic              so = 1'b0;
  logic [CH-1:0]     sh = '0;
  logic              err_clr = 1'b0;
  logic [CH*OW-1:0]  sample;
  logic [CH-1:0]     vld, ferr, eerr;

  always #5 clk = ~clk;

  ikaopm_dac_rx #(.CHANNELS(CH), .OUT_WIDTH(OW), .FRAME_BITS(13)) dut (
    .i_EMUCLK      (clk),
    .i_IC_n        (rst_n),
    .i_phi1_PCEN_n (pcen_n),
    .i_phi1_NCEN_n (ncen_n),
    .i_SO          (so),
    .i_SH          (sh),
    .i_ERR_CLR     (err_clr),
    .o_SAMPLE      (sample),
    .o_VALID       (vld),
    .o_FRAME_ERR   (ferr),
    .o_EXP0_ERR    (eerr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state: serial history, per-channel bit counts and last strobe level.
  logic [12:0]   hist;
  int            cnt [CH];
  logic [CH-1:0] prev;
  logic [OW-1:0] exp_smp [CH];
  logic [CH-1:0] exp_vld, exp_ferr, exp_eerr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_dec(input logic [12:0] w);
    int e, m, v;
    e = int'(w[12:10]);
    m = int'(w[8:0]);
    if (e == 0)     v = 0;
    else if (w[9])  v = m * (1 << (e - 1));
    else            v = -((511 - m) * (1 << (e - 1)));
    return 16'(v);
  endfunction

  function automatic void model_reset();
    hist = '0;
    prev = '0;
    for (int c = 0; c < CH; c++) begin
      cnt[c]     = 15;
      exp_smp[c] = '0;
    end
    exp_vld  = '0;
    exp_ferr = '0;
    exp_eerr = '0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < CH; c++) chk("sample", 32'(sample[c*OW +: OW]), 32'(exp_smp[c]));
      chk("valid", 32'(vld), 32'(exp_vld));
      chk("frame_err", 32'(ferr), 32'(exp_ferr));
      chk("exp0_err", 32'(eerr), 32'(exp_eerr));
    end
  end

  // One phi1 period = 4 EMUCLKs: PCEN in slot 0, NCEN in slot 2.
  // clr: 0 none, 1 ERR_CLR in slot 0, 2 ERR_CLR coincident with the flag-set edge.
  task automatic phi(input logic b, input logic [CH-1:0] s, input int clr);
    logic [CH-1:0] evt, shrt;
    logic [12:0]   word;
    @(posedge clk); #1;
    pcen_n = 1'b0; so = b; sh = s; err_clr = (clr == 1); exp_vld = '0;
    hist = {b, hist[12:1]};
    word = hist;
    evt  = '0;
    shrt = '0;
    for (int c = 0; c < CH; c++) begin
      cnt[c] = (cnt[c] < 15) ? cnt[c] + 1 : 15;
      if (prev[c] && !s[c]) begin
        evt[c]  = 1'b1;
        shrt[c] = (cnt[c] < 13);
        cnt[c]  = 0;
      end
      prev[c] = s[c];
    end
    @(posedge clk); #1;
    pcen_n = 1'b1; err_clr = 1'b0;
    if (clr == 1) begin exp_ferr = '0; exp_eerr = '0; end
    @(posedge clk); #1;
    ncen_n = 1'b0; err_clr = (clr == 2);
    @(posedge clk); #1;
    ncen_n = 1'b1; err_clr = 1'b0;
    if (clr == 2) begin exp_ferr = '0; exp_eerr = '0; end
    for (int c = 0; c < CH; c++) begin
      if (evt[c]) begin
        exp_smp[c] = {model_dec(word), 8'h00};
        exp_vld[c] = 1'b1;
        if (shrt[c]) exp_ferr[c] = 1'b1;
        if (word[12:10] == 3'd0) exp_eerr[c] = 1'b1;
      end
    end
  endtask

  // Shifts nbits serially so the latched word's top bits are w; strobe on the second-last bit.
  task automatic send_frame(input logic [12:0] w, input int nbits, input logic [CH-1:0] mask,
                            input int clr);
    for (int i = 0; i < nbits; i++) begin
      int   idx;
      logic b;
      idx = i + 13 - nbits;
      b   = (idx >= 0 && idx < 13) ? w[idx] : 1'b0;
      phi(b, (i == nbits - 2) ? mask : '0, (i == nbits - 1) ? clr : 0);
    end
  endtask

  task automatic do_reset(input int hold);
    #2;
    rst_n = 1'b0; pcen_n = 1'b1; ncen_n = 1'b1; err_clr = 1'b0; sh = '0; so = 1'b0;
    model_reset();
    #1;
    chk("rst_smp0", 32'(sample[OW-1:0]), 32'h0);
    chk("rst_smp1", 32'(sample[2*OW-1:OW]), 32'h0);
    chk("rst_flags", 32'({vld, ferr, eerr}), 32'h0);
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // e=3 m=0x3FF on SH1
    send_frame(13'h0FFF, 13, 2'b01, 0);
    chk("r31_smp0", 32'(sample[OW-1:0]), 32'h07FC00);
    chk("r31_vld", 32'(vld), 32'h1);
    chk("r31_flags", 32'({ferr, eerr}), 32'h0);

    // e=7 m=0 on SH2; channel 0 holds
    send_frame(13'h1C00, 13, 2'b10, 0);
    chk("r32_smp1", 32'(sample[2*OW-1:OW]), 32'h804000);
    chk("r32_smp0", 32'(sample[OW-1:0]), 32'h07FC00);
    chk("r32_vld", 32'(vld), 32'h2);

    // exponent zero, then clear
    send_frame(13'h0000, 13, 2'b01, 0);
    chk("r33_smp0", 32'(sample[OW-1:0]), 32'h0);
    chk("r33_eerr", 32'(eerr), 32'h1);
    phi(1'b0, '0, 1);
    chk("r33_clr", 32'(eerr), 32'h0);

    // frame length boundary: 13 ok, 12 short, 13 with clear leaves no error
    send_frame(13'h0ABC, 13, 2'b01, 0);
    chk("len13_ferr", 32'(ferr), 32'h0);
    send_frame(13'h1555, 12, 2'b01, 0);
    chk("len12_ferr", 32'(ferr), 32'h1);
    send_frame(13'h0FFF, 13, 2'b01, 1);
    chk("len13_after_clr", 32'(ferr), 32'h0);
    chk("len13_smp0", 32'(sample[OW-1:0]), 32'h07FC00);

    // short 8-bit frame with coincident clear: set wins
    send_frame(13'h1F00, 8, 2'b01, 2);
    chk("setwins_ferr", 32'(ferr), 32'h1);
    chk("setwins_vld", 32'(vld), 32'h1);
    phi(1'b0, '0, 1);

    // e=1 m=0x201, left-aligned in 24 bits
    send_frame(13'h0601, 13, 2'b01, 0);
    chk("r35_smp0", 32'(sample[OW-1:0]), 32'h000100);

    // simultaneous load on both channels
    send_frame(13'h1234, 13, 2'b11, 0);
    chk("both_vld", 32'(vld), 32'h3);
    chk("both_smp0", 32'(sample[OW-1:0]), 32'h01A000);
    chk("both_smp1", 32'(sample[2*OW-1:OW]), 32'h01A000);

    // reset mid-frame with strobes high; no load may follow
    for (int i = 0; i < 5; i++) phi(1'b1, '0, 0);
    phi(1'b1, 2'b11, 0);
    do_reset(3);
    for (int i = 0; i < 3; i++) phi(1'b0, '0, 0);
    chk("post_rst_vld", 32'(vld), 32'h0);
    chk("post_rst_smp", 32'(sample[OW-1:0]), 32'h0);

    // randomized strobes, data and clears
    for (int i = 0; i < 700; i++) begin
      logic [CH-1:0] s;
      int            clr;
      for (int c = 0; c < CH; c++) s[c] = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0;
      phi(1'($urandom), s, clr);
      if (i == 350) do_reset(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
